// File: rtl/mix_freq_pkg.sv
// mix_freq_pkg
//   Shared definitions for the mixer-frequency configuration sequencer:
//   the sequencer state encoding, result codes reported on err_code, the
//   AXI OKAY response value and the register stride of the mix_freq_set bank.
package mix_freq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_RESP     = 2'd1;
    localparam logic [1:0] ERR_MISMATCH = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int         REG_STRIDE    = 4;

    // Byte offset of register idx inside the bank.
    function automatic logic [31:0] reg_offset(input logic [4:0] idx);
        return 32'(idx) * 32'(REG_STRIDE);
    endfunction

endpackage

// File: rtl/mix_freq_cfg_sequencer_hs_tracker.sv
// axil_hs_tracker
//   Holds one AXI VALID from launch until its READY is seen, then records
//   that the handshake completed. Used for the AW, W and AR channels.
// Ports
//   clk, rst  clock and asynchronous active-high reset
//   launch    raise VALID and clear the done flag
//   abort     drop VALID without completing (sequence aborted)
//   ready     channel READY from the slave
//   valid     channel VALID to the slave
//   done      handshake completed since the last launch
module axil_hs_tracker (
    input  logic clk,
    input  logic rst,
    input  logic launch,
    input  logic abort,
    input  logic ready,
    output logic valid,
    output logic done
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            done  <= 1'b0;
        end else if (abort) begin
            valid <= 1'b0;
        end else if (launch) begin
            valid <= 1'b1;
            done  <= 1'b0;
        end else if (valid && ready) begin
            valid <= 1'b0;
            done  <= 1'b1;
        end
    end

endmodule

// File: rtl/mix_freq_cfg_sequencer.sv
// mix_freq_cfg_sequencer
//   AXI4-Lite master that writes NUM_REGS captured 32-bit frequency words to
//   consecutive registers starting at BASE_ADDR, optionally reads them all
//   back to verify, and reports the outcome.
// Ports
//   ACLK, ARESET      clock, asynchronous active-high reset
//   start, verify_en  start pulse (IDLE only) and read-back enable
//   freq_words        word i at [32i+31:32i], captured on accepted start
//   busy, done        sequence running / one-cycle end pulse
//   err, err_code     sticky result of the last sequence
//   m_axi_aw*/w*/b*   AXI4-Lite write channels
//   m_axi_ar*/r*      AXI4-Lite read channels
module mix_freq_cfg_sequencer
    import mix_freq_pkg::*;
#(
    parameter int                NUM_REGS    = 4,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                TIMEOUT_CYC = 1024
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     start,
    input  logic                     verify_en,
    input  logic [NUM_REGS*32-1:0]   freq_words,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [ADDR_W-1:0]        m_axi_awaddr,
    output logic                     m_axi_awvalid,
    input  logic                     m_axi_awready,
    output logic [31:0]              m_axi_wdata,
    output logic                     m_axi_wvalid,
    input  logic                     m_axi_wready,
    input  logic [1:0]               m_axi_bresp,
    input  logic                     m_axi_bvalid,
    output logic                     m_axi_bready,
    output logic [ADDR_W-1:0]        m_axi_araddr,
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,
    input  logic [31:0]              m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    seq_state_t        state_q, state_nxt;
    logic [IDX_W-1:0]  idx_q, idx_nxt;
    logic [1:0]        err_code_q, err_code_nxt;
    logic [31:0]       words_q [NUM_REGS];
    logic              verify_q;
    logic              drain_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic              tmo_hit;

    logic              aw_vld, aw_done, w_vld, w_done, ar_vld, ar_done;
    logic              launch_wr, launch_rd, abort_all, start_acc;
    logic [31:0]       cur_word;
    logic [ADDR_W-1:0] reg_addr;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign cur_word  = words_q[idx_q];
    assign reg_addr  = BASE_ADDR + ADDR_W'(reg_offset(5'(idx_q)));
    assign tmo_hit   = (tmo_cnt_q == TMO_LAST);

    // Channel VALIDs rise on entry to their state and are dropped by the
    // trackers themselves, so they never depend combinationally on READY.
    assign launch_wr = (state_nxt == ST_WR_AW_W) && (state_q != ST_WR_AW_W);
    assign launch_rd = (state_nxt == ST_RD_AR)   && (state_q != ST_RD_AR);
    assign abort_all = (state_nxt == ST_DONE);

    axil_hs_tracker u_aw (
        .clk    (ACLK),
        .rst    (ARESET),
        .launch (launch_wr),
        .abort  (abort_all),
        .ready  (m_axi_awready),
        .valid  (aw_vld),
        .done   (aw_done)
    );

    axil_hs_tracker u_w (
        .clk    (ACLK),
        .rst    (ARESET),
        .launch (launch_wr),
        .abort  (abort_all),
        .ready  (m_axi_wready),
        .valid  (w_vld),
        .done   (w_done)
    );

    axil_hs_tracker u_ar (
        .clk    (ACLK),
        .rst    (ARESET),
        .launch (launch_rd),
        .abort  (abort_all),
        .ready  (m_axi_arready),
        .valid  (ar_vld),
        .done   (ar_done)
    );

    // State register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state, index and result code
    always_comb begin
        state_nxt    = state_q;
        idx_nxt      = idx_q;
        err_code_nxt = err_code_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_nxt    = ST_WR_AW_W;
                    idx_nxt      = '0;
                    err_code_nxt = ERR_NONE;
                end
            end
            ST_WR_AW_W: begin
                // Both address and data must be accepted, in either order.
                if (aw_done && w_done) begin
                    state_nxt = ST_WR_B;
                end else if (tmo_hit) begin
                    state_nxt    = ST_DONE;
                    err_code_nxt = ERR_TIMEOUT;
                end
            end
            ST_WR_B: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != AXI_RESP_OKAY) begin
                        state_nxt    = ST_DONE;
                        err_code_nxt = ERR_RESP;
                    end else if (idx_q != LAST_IDX) begin
                        idx_nxt   = idx_q + IDX_W'(1);
                        state_nxt = ST_WR_AW_W;
                    end else if (verify_q) begin
                        idx_nxt   = '0;
                        state_nxt = ST_RD_AR;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end else if (tmo_hit) begin
                    state_nxt    = ST_DONE;
                    err_code_nxt = ERR_TIMEOUT;
                end
            end
            ST_RD_AR: begin
                if (ar_done) begin
                    state_nxt = ST_RD_R;
                end else if (tmo_hit) begin
                    state_nxt    = ST_DONE;
                    err_code_nxt = ERR_TIMEOUT;
                end
            end
            ST_RD_R: begin
                if (m_axi_rvalid) begin
                    if (m_axi_rresp != AXI_RESP_OKAY) begin
                        state_nxt    = ST_DONE;
                        err_code_nxt = ERR_RESP;
                    end else if (m_axi_rdata != cur_word) begin
                        state_nxt    = ST_DONE;
                        err_code_nxt = ERR_MISMATCH;
                    end else if (idx_q != LAST_IDX) begin
                        idx_nxt   = idx_q + IDX_W'(1);
                        state_nxt = ST_RD_AR;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end else if (tmo_hit) begin
                    state_nxt    = ST_DONE;
                    err_code_nxt = ERR_TIMEOUT;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        m_axi_bready = 1'b0;
        m_axi_rready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // After a timeout, swallow any late response still in flight.
                m_axi_bready = drain_q;
                m_axi_rready = drain_q;
            end
            ST_WR_AW_W: busy = 1'b1;
            ST_WR_B: begin
                busy         = 1'b1;
                m_axi_bready = 1'b1;
            end
            ST_RD_AR: busy = 1'b1;
            ST_RD_R: begin
                busy         = 1'b1;
                m_axi_rready = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Address/data buses are held at zero whenever their VALID is low.
    assign m_axi_awvalid = aw_vld;
    assign m_axi_awaddr  = aw_vld ? reg_addr : '0;
    assign m_axi_wvalid  = w_vld;
    assign m_axi_wdata   = w_vld ? cur_word : '0;
    assign m_axi_arvalid = ar_vld;
    assign m_axi_araddr  = ar_vld ? reg_addr : '0;
    assign err_code      = err_code_q;
    assign err           = (err_code_q != ERR_NONE);

    // Per-wait-state timeout counter, restarted on every state change.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            tmo_cnt_q <= '0;
        end else if (state_nxt != state_q) begin
            tmo_cnt_q <= '0;
        end else if (tmo_cnt_q != TMO_LAST) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end

    // Sequence context: index, result, captured words and drain flag
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            idx_q      <= '0;
            err_code_q <= ERR_NONE;
            verify_q   <= 1'b0;
            drain_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                words_q[i] <= '0;
            end
        end else begin
            idx_q      <= idx_nxt;
            err_code_q <= err_code_nxt;
            if (start_acc) begin
                verify_q <= verify_en;
                drain_q  <= 1'b0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    words_q[i] <= freq_words[32*i +: 32];
                end
            end else if (abort_all && (err_code_nxt == ERR_TIMEOUT)) begin
                drain_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mix_freq_cfg_sequencer.sv
// tb_mix_freq_cfg_sequencer
//   Directed bench: a small AXI4-Lite register-bank slave with configurable
//   AWREADY delay, BRESP error index, read-back corruption and AR blocking
//   drives the sequencer through a fixed list of scenarios.
module tb_mix_freq_cfg_sequencer;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] SENT = 32'hFFFF_FFFF;

    logic         ACLK;
    logic         ARESET;
    logic         start;
    logic         verify_en;
    logic [127:0] freq_words;
    logic         busy, done, err;
    logic [1:0]   err_code;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [1:0]   bresp, rresp;

    mix_freq_cfg_sequencer #(
        .NUM_REGS    (4),
        .ADDR_W      (32),
        .BASE_ADDR   (BASE),
        .TIMEOUT_CYC (16)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .start         (start),
        .verify_en     (verify_en),
        .freq_words    (freq_words),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_code      (err_code),
        .m_axi_awaddr  (awaddr),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // ---------------- slave model ----------------
    int          aw_delay  = 0;
    int          b_err_idx = -1;
    int          r_bad_idx = -1;
    logic        ar_block  = 1'b0;
    logic        slv_clr   = 1'b0;
    logic [31:0] regs [16];
    int          aw_wait   = 0;
    int          aw_hs     = 0;
    int          w_hs      = 0;
    int          rd_hs     = 0;
    int          aw_first  = -1;
    int          w_first   = -1;
    int          cyc       = 0;
    logic        got_aw    = 1'b0;
    logic        got_w     = 1'b0;
    logic [31:0] aw_l      = '0;
    logic [31:0] w_l       = '0;

    wire        aw_now  = awvalid && awready;
    wire        w_now   = wvalid && wready;
    wire        have_aw = got_aw || aw_now;
    wire        have_w  = got_w || w_now;
    wire [31:0] b_addr  = got_aw ? aw_l : awaddr;
    wire [31:0] b_data  = got_w ? w_l : wdata;
    wire [31:0] b_off   = (b_addr - BASE) >> 2;
    wire [31:0] r_off   = (araddr - BASE) >> 2;
    wire [3:0]  b_idx   = b_off[3:0];
    wire [3:0]  r_idx   = r_off[3:0];

    assign awready = awvalid && (aw_wait >= aw_delay);
    assign wready  = 1'b1;
    assign arready = !ar_block;

    initial begin
        bvalid = 1'b0;
        rvalid = 1'b0;
        bresp  = 2'b00;
        rresp  = 2'b00;
        rdata  = '0;
    end

    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (ARESET) begin
            bvalid  <= 1'b0;
            rvalid  <= 1'b0;
            got_aw  <= 1'b0;
            got_w   <= 1'b0;
            aw_wait <= 0;
        end else begin
            if (awvalid && !awready) aw_wait <= aw_wait + 1;
            else                     aw_wait <= 0;
            if (aw_now) begin
                got_aw <= 1'b1;
                aw_l   <= awaddr;
                aw_hs  <= aw_hs + 1;
                if (aw_first < 0) aw_first <= cyc;
            end
            if (w_now) begin
                got_w <= 1'b1;
                w_l   <= wdata;
                w_hs  <= w_hs + 1;
                if (w_first < 0) w_first <= cyc;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (have_aw && have_w && (!bvalid || bready)) begin
                got_aw <= 1'b0;
                got_w  <= 1'b0;
                bvalid <= 1'b1;
                if (int'(b_idx) == b_err_idx) begin
                    bresp <= 2'b10;
                end else begin
                    bresp        <= 2'b00;
                    regs[b_idx]  <= b_data;
                end
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rresp  <= 2'b00;
                rd_hs  <= rd_hs + 1;
                rdata  <= (int'(r_idx) == r_bad_idx) ? 32'h0000_DEAD : regs[r_idx];
            end
        end
        if (slv_clr) begin
            for (int i = 0; i < 16; i++) regs[i] <= SENT;
            aw_hs    <= 0;
            w_hs     <= 0;
            rd_hs    <= 0;
            aw_first <= -1;
            w_first  <= -1;
        end
    end

    // ---------------- checking ----------------
    int tests = 0;
    int fails = 0;
    int busy_cyc, ar_k, done_k;
    logic seen_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_slave();
        @(negedge ACLK);
        slv_clr = 1'b1;
        @(negedge ACLK);
        slv_clr = 1'b0;
    endtask

    // Start a sequence and follow it to its done pulse, counting busy cycles
    // and the cycle of the first ARVALID. poke_at>=0 re-pulses start mid-run.
    task automatic run_seq(input logic [127:0] words, input logic ven, input int poke_at);
        int k;
        @(negedge ACLK);
        start      = 1'b1;
        freq_words = words;
        verify_en  = ven;
        @(negedge ACLK);
        start     = 1'b0;
        busy_cyc  = 0;
        ar_k      = -1;
        done_k    = -1;
        seen_done = 1'b0;
        k         = 0;
        while (!seen_done && k < 400) begin
            if (done) begin
                seen_done = 1'b1;
                done_k    = k;
            end else begin
                if (busy) busy_cyc++;
                if (arvalid && ar_k < 0) ar_k = k;
                if (k == poke_at) begin
                    start      = 1'b1;
                    freq_words = ~words;
                    verify_en  = !ven;
                end else begin
                    start = 1'b0;
                end
                @(negedge ACLK);
                k++;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(seen_done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        ARESET     = 1'b1;
        start      = 1'b0;
        verify_en  = 1'b0;
        freq_words = '0;

        // Reset values
        repeat (3) @(negedge ACLK);
        check("rst_ctrl", 32'({busy, done, err, err_code, awvalid, wvalid, bready, arvalid, rready}), 32'd0);
        check("rst_awaddr", awaddr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_araddr", araddr, 32'd0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("idle_readies", 32'({bready, rready}), 32'd0);

        // Zero-wait slave, verify on
        clear_slave();
        run_seq({32'd4, 32'd3, 32'd2, 32'd1}, 1'b1, -1);
        check("t1_busy_cycles", busy_cyc, 32'd24);
        check("t1_busy_at_done", 32'(busy), 32'd0);
        check("t1_err", 32'({err, err_code}), 32'd0);
        check("t1_reg0", regs[0], 32'd1);
        check("t1_reg1", regs[1], 32'd2);
        check("t1_reg2", regs[2], 32'd3);
        check("t1_reg3", regs[3], 32'd4);
        check("t1_reads", rd_hs, 32'd4);
        @(negedge ACLK);
        check("t1_done_pulse", 32'(done), 32'd0);

        // AWREADY 3 cycles late, WREADY immediate; extra start while busy
        aw_delay = 3;
        clear_slave();
        run_seq({32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000}, 1'b0, 5);
        check("t2_busy_cycles", busy_cyc, 32'd24);
        check("t2_w_before_aw", 32'(w_first < aw_first), 32'd1);
        check("t2_aw_count", aw_hs, 32'd4);
        check("t2_w_count", w_hs, 32'd4);
        check("t2_reg0", regs[0], 32'hA0A0_0000);
        check("t2_reg3", regs[3], 32'hA3A3_0003);
        check("t2_no_reads", rd_hs, 32'd0);
        check("t2_err", 32'(err), 32'd0);
        aw_delay = 0;
        @(negedge ACLK);
        check("t2_idle_after", 32'(busy), 32'd0);

        // SLVERR on index 2
        b_err_idx = 2;
        clear_slave();
        run_seq({32'd44, 32'd33, 32'd22, 32'd11}, 1'b1, -1);
        check("t3_busy_cycles", busy_cyc, 32'd9);
        check("t3_err", 32'(err), 32'd1);
        check("t3_err_code", 32'(err_code), 32'd1);
        check("t3_reg1", regs[1], 32'd22);
        check("t3_reg3_untouched", regs[3], SENT);
        check("t3_aw_count", aw_hs, 32'd3);
        check("t3_no_reads", rd_hs, 32'd0);
        b_err_idx = -1;

        // Corrupted read-back of index 1
        r_bad_idx = 1;
        clear_slave();
        run_seq({32'd8, 32'd7, 32'd6, 32'd5}, 1'b1, -1);
        check("t4_busy_cycles", busy_cyc, 32'd18);
        check("t4_err_code", 32'(err_code), 32'd2);
        check("t4_reads", rd_hs, 32'd2);
        check("t4_reg3", regs[3], 32'd8);
        r_bad_idx = -1;

        // ARREADY never asserted
        ar_block = 1'b1;
        clear_slave();
        run_seq({32'h0D, 32'h0C, 32'h0B, 32'h0A}, 1'b1, -1);
        check("t5_ar_to_done", done_k - ar_k, 32'd16);
        check("t5_ar_rise", ar_k, 32'd12);
        check("t5_err_code", 32'(err_code), 32'd3);
        check("t5_arvalid_low", 32'(arvalid), 32'd0);
        check("t5_reads", rd_hs, 32'd0);
        @(negedge ACLK);
        check("t5_drain_readies", 32'({bready, rready}), 32'd3);
        ar_block = 1'b0;

        // Reset while waiting on the write response
        clear_slave();
        @(negedge ACLK);
        start      = 1'b1;
        freq_words = {32'd40, 32'd30, 32'd20, 32'd10};
        verify_en  = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        check("t6_err_cleared", 32'({err, err_code}), 32'd0);
        check("t6_busy", 32'(busy), 32'd1);
        k = 0;
        while (!(bready && busy) && k < 50) begin
            @(negedge ACLK);
            k++;
        end
        check("t6_in_wr_b", 32'(bready && busy), 32'd1);
        ARESET = 1'b1;
        #1;
        check("t6_rst_ctrl", 32'({busy, done, err, err_code, awvalid, wvalid, bready, arvalid, rready}), 32'd0);
        check("t6_rst_buses", awaddr | wdata | araddr, 32'd0);
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("t6_idle_after", 32'({busy, done, bready}), 32'd0);

        // Clean sequence after reset
        clear_slave();
        run_seq({32'h1234_5678, 32'h0BAD_F00D, 32'h0000_0002, 32'h8000_0001}, 1'b1, -1);
        check("t7_busy_cycles", busy_cyc, 32'd24);
        check("t7_err", 32'(err), 32'd0);
        check("t7_reg0", regs[0], 32'h8000_0001);
        check("t7_reg3", regs[3], 32'h1234_5678);
        check("t7_reads", rd_hs, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
